// File: rtl/fir_xifu_ctrl.sv
// FIR XIFU scoreboard: tracks XIF instruction IDs from issue through commit/kill to WB clear,
// and holds decode off while an ID is still in flight.
package fir_xifu_pkg;
  localparam int X_ID_WIDTH = 4;
  localparam int X_ID_MAX   = 2 ** X_ID_WIDTH;

  typedef struct packed {
    logic                  issue;
    logic [X_ID_WIDTH-1:0] id;
  } id2ctrl_t;

  typedef struct packed {
    logic [X_ID_MAX-1:0] clear;
  } wb2ctrl_t;

  typedef struct packed {
    logic [X_ID_MAX-1:0] commit;
  } ctrl2ex_t;

  typedef struct packed {
    logic [X_ID_MAX-1:0] issue;
    logic [X_ID_MAX-1:0] commit;
    logic [X_ID_MAX-1:0] kill;
  } ctrl2wb_t;
endpackage

module fir_xifu_ctrl
  import fir_xifu_pkg::*;
#(
  parameter int X_ID_WIDTH = fir_xifu_pkg::X_ID_WIDTH,
  parameter int X_ID_MAX   = 2 ** X_ID_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  id2ctrl_t              id2ctrl_i,
  output logic                  issue_ready_o,
  input  logic                  x_commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] x_commit_id_i,
  input  logic                  x_commit_kill_i,
  input  wb2ctrl_t              wb2ctrl_i,
  output ctrl2ex_t              ctrl2ex_o,
  output ctrl2wb_t              ctrl2wb_o,
  output logic [X_ID_WIDTH:0]   outstanding_o,
  output logic                  err_o
);

  logic [X_ID_MAX-1:0] issue_q, issue_d;
  logic [X_ID_MAX-1:0] commit_q, commit_d;
  logic [X_ID_MAX-1:0] kill_q, kill_d;
  logic                err_q, err_d;
  logic [X_ID_MAX-1:0] commit_onehot;
  logic [X_ID_WIDTH:0] popcount;

  always_comb begin
    logic issue_hit, issue_ok, cmt_hit, cmt_ok, cmt_err, issue_err, clear_err;
    issue_d = issue_q;
    commit_d = commit_q;
    kill_d = kill_q;
    err_d = 1'b0;
    for (int i = 0; i < X_ID_MAX; i++) begin
      issue_hit = id2ctrl_i.issue && (id2ctrl_i.id == X_ID_WIDTH'(i));
      issue_ok  = issue_hit && (!issue_q[i] || wb2ctrl_i.clear[i]);
      issue_err = issue_hit && issue_q[i] && !wb2ctrl_i.clear[i];
      clear_err = wb2ctrl_i.clear[i] && !issue_q[i];
      cmt_hit   = x_commit_valid_i && (x_commit_id_i == X_ID_WIDTH'(i));
      // A freshly issued instance has no commit/kill history, even if the old one had.
      cmt_err   = cmt_hit && !issue_ok && (!issue_q[i] || commit_q[i] || kill_q[i]);
      cmt_ok    = cmt_hit && !cmt_err;
      if (issue_ok) begin
        issue_d[i]  = 1'b1;
        commit_d[i] = cmt_ok && !x_commit_kill_i;
        kill_d[i]   = cmt_ok && x_commit_kill_i;
      end else if (wb2ctrl_i.clear[i]) begin
        issue_d[i]  = 1'b0;
        commit_d[i] = 1'b0;
        kill_d[i]   = 1'b0;
      end else if (cmt_ok) begin
        if (x_commit_kill_i) kill_d[i] = 1'b1;
        else                 commit_d[i] = 1'b1;
      end
      if (issue_err || cmt_err || clear_err) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_q  <= '0;
      commit_q <= '0;
      kill_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      issue_q  <= issue_d;
      commit_q <= commit_d;
      kill_q   <= kill_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    commit_onehot = '0;
    if (x_commit_valid_i && !x_commit_kill_i) commit_onehot[x_commit_id_i] = 1'b1;
  end

  always_comb begin
    popcount = '0;
    for (int i = 0; i < X_ID_MAX; i++) popcount = popcount + (X_ID_WIDTH + 1)'(issue_q[i]);
  end

  assign issue_ready_o    = !issue_q[id2ctrl_i.id] || wb2ctrl_i.clear[id2ctrl_i.id];
  assign ctrl2ex_o.commit = commit_q | commit_onehot;
  assign ctrl2wb_o.issue  = issue_q;
  assign ctrl2wb_o.commit = commit_q;
  assign ctrl2wb_o.kill   = kill_q;
  assign outstanding_o    = popcount;
  assign err_o            = err_q;

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Directed testbench for fir_xifu_ctrl: lifecycle, kill, same-cycle events, full, errors, async reset.
module tb_fir_xifu_ctrl;
  import fir_xifu_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  id2ctrl_t        id2ctrl_i;
  logic            issue_ready_o;
  logic            x_commit_valid_i;
  logic [3:0]      x_commit_id_i;
  logic            x_commit_kill_i;
  wb2ctrl_t        wb2ctrl_i;
  ctrl2ex_t        ctrl2ex_o;
  ctrl2wb_t        ctrl2wb_o;
  logic [4:0]      outstanding_o;
  logic            err_o;

  int compare_cnt = 0;
  int fail_cnt = 0;

  fir_xifu_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .id2ctrl_i       (id2ctrl_i),
    .issue_ready_o   (issue_ready_o),
    .x_commit_valid_i(x_commit_valid_i),
    .x_commit_id_i   (x_commit_id_i),
    .x_commit_kill_i (x_commit_kill_i),
    .wb2ctrl_i       (wb2ctrl_i),
    .ctrl2ex_o       (ctrl2ex_o),
    .ctrl2wb_o       (ctrl2wb_o),
    .outstanding_o   (outstanding_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic applyStimulus(input logic iss, input logic [3:0] iid, input logic cv,
                               input logic [3:0] cid, input logic kill, input logic [15:0] clr);
    id2ctrl_i.issue  = iss;
    id2ctrl_i.id     = iid;
    x_commit_valid_i = cv;
    x_commit_id_i    = cid;
    x_commit_kill_i  = kill;
    wb2ctrl_i.clear  = clr;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0000);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    idle();
    #1;
    checkOutput("rst_wb_issue", 32'(ctrl2wb_o.issue), 32'h0);
    checkOutput("rst_wb_commit", 32'(ctrl2wb_o.commit), 32'h0);
    checkOutput("rst_wb_kill", 32'(ctrl2wb_o.kill), 32'h0);
    checkOutput("rst_ex_commit", 32'(ctrl2ex_o.commit), 32'h0);
    checkOutput("rst_outstanding", 32'(outstanding_o), 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    checkOutput("rst_ready", 32'(issue_ready_o), 32'd1);
    step();
    rst_i = 1'b0;

    // Basic lifecycle
    applyStimulus(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 16'h0);
    checkOutput("life_ready", 32'(issue_ready_o), 32'd1);
    step(); idle();
    checkOutput("life_issue", 32'(ctrl2wb_o.issue), 32'h0008);
    checkOutput("life_outstanding", 32'(outstanding_o), 32'd1);
    checkOutput("life_err0", 32'(err_o), 32'd0);
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 16'h0);
    checkOutput("life_ex_bypass", 32'(ctrl2ex_o.commit), 32'h0008);
    checkOutput("life_wb_commit_pre", 32'(ctrl2wb_o.commit), 32'h0000);
    step(); idle();
    checkOutput("life_wb_commit", 32'(ctrl2wb_o.commit), 32'h0008);
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0008);
    step(); idle();
    checkOutput("life_clr_issue", 32'(ctrl2wb_o.issue), 32'h0);
    checkOutput("life_clr_commit", 32'(ctrl2wb_o.commit), 32'h0);
    checkOutput("life_clr_outstanding", 32'(outstanding_o), 32'd0);
    checkOutput("life_clr_err", 32'(err_o), 32'd0);

    // Kill path
    applyStimulus(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 16'h0);
    step();
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd5, 1'b1, 16'h0);
    checkOutput("kill_ex_nobypass", 32'(ctrl2ex_o.commit), 32'h0);
    step(); idle();
    checkOutput("kill_wb_kill", 32'(ctrl2wb_o.kill), 32'h0020);
    checkOutput("kill_wb_commit", 32'(ctrl2wb_o.commit), 32'h0);
    checkOutput("kill_wb_issue", 32'(ctrl2wb_o.issue), 32'h0020);
    checkOutput("kill_ex_commit", 32'(ctrl2ex_o.commit), 32'h0);
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0020);
    step(); idle();
    checkOutput("kill_clr_kill", 32'(ctrl2wb_o.kill), 32'h0);
    checkOutput("kill_clr_issue", 32'(ctrl2wb_o.issue), 32'h0);

    // Same-cycle issue + commit, then clear + reissue
    applyStimulus(1'b1, 4'd7, 1'b1, 4'd7, 1'b0, 16'h0);
    step(); idle();
    checkOutput("same_issue", 32'(ctrl2wb_o.issue), 32'h0080);
    checkOutput("same_commit", 32'(ctrl2wb_o.commit), 32'h0080);
    checkOutput("same_err", 32'(err_o), 32'd0);
    applyStimulus(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 16'h0080);
    checkOutput("reissue_ready", 32'(issue_ready_o), 32'd1);
    step(); idle();
    checkOutput("reissue_issue", 32'(ctrl2wb_o.issue), 32'h0080);
    checkOutput("reissue_commit", 32'(ctrl2wb_o.commit), 32'h0);
    checkOutput("reissue_err", 32'(err_o), 32'd0);
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0080);
    step(); idle();

    // Full
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0, 4'd0, 1'b0, 16'h0);
      step();
    end
    idle();
    checkOutput("full_outstanding", 32'(outstanding_o), 32'd16);
    checkOutput("full_err0", 32'(err_o), 32'd0);
    applyStimulus(1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 16'h0);
    checkOutput("full_ready", 32'(issue_ready_o), 32'd0);
    step(); idle();
    checkOutput("full_err", 32'(err_o), 32'd1);
    checkOutput("full_issue", 32'(ctrl2wb_o.issue), 32'hFFFF);
    checkOutput("full_commit", 32'(ctrl2wb_o.commit), 32'h0);
    step();
    checkOutput("full_err_drop", 32'(err_o), 32'd0);
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'hFFFF);
    step(); idle();
    checkOutput("full_drained", 32'(outstanding_o), 32'd0);

    // Protocol errors
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 16'h0);
    step(); idle();
    checkOutput("perr_noissue_err", 32'(err_o), 32'd1);
    checkOutput("perr_noissue_commit", 32'(ctrl2wb_o.commit), 32'h0);
    step();
    checkOutput("perr_noissue_pulse", 32'(err_o), 32'd0);
    applyStimulus(1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 16'h0);
    step();
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd6, 1'b0, 16'h0);
    step();
    checkOutput("perr_first_commit_ok", 32'(err_o), 32'd0);
    step(); idle();
    checkOutput("perr_double_commit", 32'(err_o), 32'd1);
    checkOutput("perr_double_state", 32'(ctrl2wb_o.commit), 32'h0040);
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0040);
    step();
    checkOutput("perr_valid_clear", 32'(err_o), 32'd0);
    step(); idle();
    checkOutput("perr_idle_clear", 32'(err_o), 32'd1);
    step();
    checkOutput("perr_idle_clear_pulse", 32'(err_o), 32'd0);

    // Reset mid-flight
    applyStimulus(1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 16'h0);
    step();
    applyStimulus(1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 16'h0);
    step();
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 16'h0);
    step(); idle();
    checkOutput("mid_issue", 32'(ctrl2wb_o.issue), 32'h0012);
    checkOutput("mid_commit", 32'(ctrl2wb_o.commit), 32'h0002);
    checkOutput("mid_outstanding", 32'(outstanding_o), 32'd2);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("async_issue", 32'(ctrl2wb_o.issue), 32'h0);
    checkOutput("async_commit", 32'(ctrl2wb_o.commit), 32'h0);
    checkOutput("async_ex_commit", 32'(ctrl2ex_o.commit), 32'h0);
    checkOutput("async_outstanding", 32'(outstanding_o), 32'd0);
    checkOutput("async_ready", 32'(issue_ready_o), 32'd1);
    #1;
    rst_i = 1'b0;
    applyStimulus(1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 16'h0);
    checkOutput("post_rst_ready", 32'(issue_ready_o), 32'd1);
    step(); idle();
    checkOutput("post_rst_issue", 32'(ctrl2wb_o.issue), 32'h0002);
    checkOutput("post_rst_commit", 32'(ctrl2wb_o.commit), 32'h0);
    checkOutput("post_rst_err", 32'(err_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/fir_xifu_ctrl.md
# fir_xifu_ctrl

Scoreboard and controller for the FIR XIFU. It tracks every in-flight XIF instruction ID from issue (decode stage) through commit or kill (core commit interface) to clear (writeback stage). It publishes per-ID issue/commit/kill bitmaps to EX and WB, and back-pressures decode when an ID is still in flight. The block sits beside the ID/EX/WB pipeline: it consumes `id2ctrl_t` and `wb2ctrl_t` and produces `ctrl2ex_t` and `ctrl2wb_t`.

## Interface
- `X_ID_WIDTH`, default `fir_xifu_pkg::X_ID_WIDTH` (4): XIF ID width.
- `X_ID_MAX`, default `2**X_ID_WIDTH` (16): number of tracked IDs; one bitmap bit per ID.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `id2ctrl_i`  in  `id2ctrl_t`  `issue` pulse plus `id` of the instruction accepted by the decode stage this cycle.
- `issue_ready_o`  out  1  combinational: the ID presented on `id2ctrl_i.id` is free, so issue is permitted.
- `x_commit_valid_i`  in  1  XIF commit handshake valid (commit is always accepted).
- `x_commit_id_i`  in  X_ID_WIDTH  ID being committed or killed.
- `x_commit_kill_i`  in  1  1 = kill, 0 = commit.
- `wb2ctrl_i`  in  `wb2ctrl_t`  `clear` bitmap: IDs retired by WB this cycle; multiple bits are allowed.
- `ctrl2ex_o`  out  `ctrl2ex_t`  `commit` bitmap with same-cycle bypass.
- `ctrl2wb_o`  out  `ctrl2wb_t`  registered `issue`/`commit`/`kill` bitmaps.
- `outstanding_o`  out  X_ID_WIDTH+1  popcount of the registered issue bitmap.
- `err_o`  out  1  one-cycle registered pulse on a protocol violation.

## Operation
State: three X_ID_MAX-bit registers `issue_q`, `commit_q`, `kill_q`.

Per-ID next state for bit `i`:
- **Set issue:** `id2ctrl_i.issue && id == i && !issue_q[i]` sets `issue_q[i]`, and clears `commit_q[i]` and `kill_q[i]`.
- **Clear:** `wb2ctrl_i.clear[i]` clears all three bits for `i`.
- **Commit:** `x_commit_valid_i && x_commit_id_i == i && !x_commit_kill_i` sets `commit_q[i]`.
- **Kill:** same condition with `x_commit_kill_i` set sets `kill_q[i]`; `commit_q[i]` is unchanged. A killed entry stays issued until WB clears it, because WB must drain it without writing the register file.

Priority, for the same ID in the same cycle:
- Issue over clear: the old instance retires and the new instance is issued.
- Clear over commit/kill, unless an issue occurs in the same cycle.
- Commit/kill in the same cycle as its own issue is legal; the result is issued plus committed (or killed).

`err_o` is asserted in the next cycle on any of these violations; the offending event is otherwise ignored:
- issue to an ID with `issue_q` set that is not being cleared in the same cycle;
- commit/kill to an ID that is neither in `issue_q` nor issued this cycle;
- commit/kill to an ID already committed or killed;
- clear of an ID that is not issued.

Outputs:
- `issue_ready_o = !issue_q[id2ctrl_i.id] || wb2ctrl_i.clear[id2ctrl_i.id]`.
- `ctrl2ex_o.commit = commit_q | onehot(x_commit_id_i)` when a commit (not a kill) is valid; otherwise `commit_q`.
- `ctrl2wb_o = {issue_q, commit_q, kill_q}`, registered only with no bypass.
- `outstanding_o = popcount(issue_q)`, range 0..X_ID_MAX inclusive, hence X_ID_WIDTH+1 bits.

## Timing
- Reset values: all bitmaps 0, `ctrl2ex_o` 0, `ctrl2wb_o` 0, `outstanding_o` 0, `err_o` 0. `issue_ready_o` is 1 during reset.
- Reset asserted mid-operation drops every in-flight ID immediately and asynchronously. No pending commit survives.
- Issue appears in `ctrl2wb_o.issue` one cycle after `id2ctrl_i.issue`.
- Commit appears in `ctrl2ex_o.commit` in the same cycle (bypass) and in `ctrl2wb_o.commit` one cycle later.
- Clear frees the ID for issue in the same cycle. The bitmaps drop the ID on the next edge.
- Full condition: `outstanding_o == X_ID_MAX`. `issue_ready_o` is then 0 for every ID unless that ID is cleared in the same cycle.
- No wrap-around logic: IDs are indices, and reuse is controlled solely by `issue_q`.

## Test plan
- **Basic lifecycle:** reset; issue id 3 -> cycle+1: `ctrl2wb_o.issue = 16'h0008`, `outstanding_o = 1`. Commit id 3 -> `ctrl2ex_o.commit = 16'h0008` in the same cycle. Clear `16'h0008` -> cycle+1: all bitmaps 0, `outstanding_o = 0`.
- **Kill path:** issue id 5, kill id 5 -> `ctrl2wb_o.kill = 16'h0020` with `commit` bit 5 = 0 and `ctrl2ex_o.commit` bit 5 never 1. Clear id 5 -> kill bit drops.
- **Same-cycle events:** issue and commit id 7 in one cycle -> cycle+1 `issue` and `commit` bit 7 both 1. With id 7 issued, clear id 7 and re-issue id 7 in one cycle -> `issue_ready_o = 1`, cycle+1 `issue` bit 7 = 1, `commit` bit 7 = 0, `err_o = 0`.
- **Full:** issue ids 0..15 -> `outstanding_o = 16` and `issue_ready_o = 0`. Issue id 9 anyway -> `err_o` pulses once and the state is unchanged.
- **Protocol errors:** commit of never-issued id 2 -> `err_o = 1` for exactly one cycle and `commit_q` stays 0. A second commit of an already-committed id -> `err_o` pulse. Clear of an idle id -> `err_o` pulse.
- **Reset mid-flight:** issue ids 1 and 4 and commit id 1, then assert `rst_i` asynchronously between edges -> all outputs 0 immediately. After release, issue id 1 is accepted with no error.
